// File: rtl/pixel_histogram_bin.sv
// ---------------------------------------------------------------------------
// pixel_histogram_bin
//
// Purpose:
//   Builds a 16-bin histogram of one camera frame and streams the bins out
//   after the frame ends. The bin of a pixel is its top four bits. Each bin
//   counter saturates rather than wrapping. A frame that starts while the
//   previous histogram is still being drained is dropped as a whole.
//
// Ports:
//   clk           single clock for all logic
//   rst           synchronous, active-high reset
//   frame_valid   high for the whole frame
//   line_valid    high while pixel_data carries an active pixel
//   pixel_data    pixel value, PIX_W bits
//   hist_ready    downstream accepts the bin currently presented
//   hist_valid    hist_bin / hist_count / hist_last are valid
//   hist_bin      bin index 0..15
//   hist_count    pixel count of hist_bin, CNT_W bits
//   hist_last     high together with bin 15
//   hist_sat      sticky per frame: some bin saturated
//   frame_dropped one-cycle pulse when a frame start is ignored
// ---------------------------------------------------------------------------
module pixel_histogram_bin #(
    parameter int PIX_W = 10,
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_valid,
    input  logic             line_valid,
    input  logic [PIX_W-1:0] pixel_data,
    input  logic             hist_ready,
    output logic             hist_valid,
    output logic [3:0]       hist_bin,
    output logic [CNT_W-1:0] hist_count,
    output logic             hist_last,
    output logic             hist_sat,
    output logic             frame_dropped
);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        ACCUM    = 2'd2,
        DUMP     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Input stage (s1)
    logic             fv_q;
    logic             lv_q;
    logic [PIX_W-1:0] pix_q;
    logic             fv_prev_q;
    // Set once s1 holds a real sample taken after reset. Without it the
    // reset value of fv_q would look like "frame_valid low" and a frame
    // already in progress at reset release would be counted.
    logic             s1_vld_q;

    // Control and histogram state
    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q [16];
    logic [CNT_W-1:0] cnt_d [16];

    // Registered outputs
    logic             hist_valid_q, hist_valid_d;
    logic [3:0]       hist_bin_q, hist_bin_d;
    logic [CNT_W-1:0] hist_count_q, hist_count_d;
    logic             hist_last_q, hist_last_d;
    logic             hist_sat_q, hist_sat_d;
    logic             frame_dropped_q, frame_dropped_d;

    // Decoded helpers
    logic             fv_rise_s;
    logic             accept_s;
    logic             count_en_s;
    logic [3:0]       pix_bin_s;
    logic [3:0]       idx_nxt_s;
    logic             unused_pix_s;

    assign fv_rise_s    = fv_q & ~fv_prev_q;
    assign accept_s     = hist_valid_q & hist_ready;
    assign pix_bin_s    = pix_q[PIX_W-1:PIX_W-4];
    assign idx_nxt_s    = idx_q + 4'd1;
    // Low pixel bits are registered with the rest of s1 but do not affect
    // the bin selection.
    assign unused_pix_s = ^pix_q[PIX_W-5:0];

    // Input stage register: samples the camera stream before any logic
    always_ff @(posedge clk) begin
        if (rst) begin
            fv_q      <= 1'b0;
            lv_q      <= 1'b0;
            pix_q     <= {PIX_W{1'b0}};
            fv_prev_q <= 1'b0;
            s1_vld_q  <= 1'b0;
        end else begin
            fv_q      <= frame_valid;
            lv_q      <= line_valid;
            pix_q     <= pixel_data;
            fv_prev_q <= fv_q;
            s1_vld_q  <= 1'b1;
        end
    end

    // Next-state, counter update and output-register next values
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        drop_d          = drop_q;
        cnt_d           = cnt_q;
        hist_valid_d    = hist_valid_q;
        hist_bin_d      = hist_bin_q;
        hist_count_d    = hist_count_q;
        hist_last_d     = hist_last_q;
        hist_sat_d      = hist_sat_q;
        frame_dropped_d = 1'b0;
        count_en_s      = 1'b0;

        case (state_q)
            WAIT_LOW: begin
                if (s1_vld_q && !fv_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_LOW;
                end
            end

            IDLE: begin
                if (fv_rise_s) begin
                    state_d    = ACCUM;
                    hist_sat_d = 1'b0;
                    for (int i = 0; i < 16; i++) begin
                        cnt_d[i] = CNT_ZERO;
                    end
                    // A pixel on the very first frame cycle belongs to the frame.
                    count_en_s = lv_q;
                end else begin
                    state_d = IDLE;
                end
            end

            ACCUM: begin
                if (!fv_q) begin
                    // Falling edge: counters are final, present bin 0.
                    state_d      = DUMP;
                    idx_d        = 4'd0;
                    drop_d       = 1'b0;
                    hist_valid_d = 1'b1;
                    hist_bin_d   = 4'd0;
                    hist_count_d = cnt_q[0];
                    hist_last_d  = 1'b0;
                end else begin
                    count_en_s = lv_q;
                end
            end

            DUMP: begin
                if (fv_rise_s) begin
                    frame_dropped_d = 1'b1;
                    drop_d          = 1'b1;
                end else begin
                    frame_dropped_d = 1'b0;
                end
                if (accept_s) begin
                    cnt_d[idx_q] = CNT_ZERO;
                    if (idx_q == 4'd15) begin
                        hist_valid_d = 1'b0;
                        hist_bin_d   = 4'd0;
                        hist_count_d = CNT_ZERO;
                        hist_last_d  = 1'b0;
                        // A frame that began during the dump is skipped whole.
                        if (drop_q || fv_rise_s) begin
                            state_d = WAIT_LOW;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d        = idx_nxt_s;
                        hist_bin_d   = idx_nxt_s;
                        hist_count_d = cnt_q[idx_nxt_s];
                        hist_last_d  = (idx_nxt_s == 4'd15);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end

            default: begin
                state_d      = WAIT_LOW;
                hist_valid_d = 1'b0;
            end
        endcase

        // Saturating increment of the selected bin
        if (count_en_s) begin
            if (cnt_d[pix_bin_s] == CNT_MAX) begin
                hist_sat_d = 1'b1;
            end else begin
                cnt_d[pix_bin_s] = cnt_d[pix_bin_s] + CNT_ONE;
            end
        end else begin
            hist_sat_d = hist_sat_d;
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= WAIT_LOW;
            idx_q           <= 4'd0;
            drop_q          <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
            hist_valid_q    <= 1'b0;
            hist_bin_q      <= 4'd0;
            hist_count_q    <= CNT_ZERO;
            hist_last_q     <= 1'b0;
            hist_sat_q      <= 1'b0;
            frame_dropped_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            drop_q          <= drop_d;
            cnt_q           <= cnt_d;
            hist_valid_q    <= hist_valid_d;
            hist_bin_q      <= hist_bin_d;
            hist_count_q    <= hist_count_d;
            hist_last_q     <= hist_last_d;
            hist_sat_q      <= hist_sat_d;
            frame_dropped_q <= frame_dropped_d;
        end
    end

    assign hist_valid    = hist_valid_q;
    assign hist_bin      = hist_bin_q;
    assign hist_count    = hist_count_q;
    assign hist_last     = hist_last_q;
    assign hist_sat      = hist_sat_q;
    assign frame_dropped = frame_dropped_q;

endmodule

// File: tb/tb_pixel_histogram_bin.sv
// Testbench for pixel_histogram_bin. Two instances share one stimulus bus:
// the default-width one and a CNT_W=4 one, whose expected counts are the
// true counts clipped to 15 with hist_sat set whenever any bin exceeded 15.
module tb_pixel_histogram_bin;
    localparam int PIX_W  = 10;
    localparam int CNT_W  = 24;
    localparam int CNT4_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             frame_valid;
    logic             line_valid;
    logic [PIX_W-1:0] pixel_data;
    logic             hist_ready;
    logic             hist_valid, hist_last, hist_sat, frame_dropped;
    logic [3:0]       hist_bin;
    logic [CNT_W-1:0] hist_count;
    logic              hv4, hl4, hs4, fd4;
    logic [3:0]        hb4;
    logic [CNT4_W-1:0] hc4;

    always #5 clk = ~clk;

    pixel_histogram_bin #(.PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .frame_valid(frame_valid), .line_valid(line_valid),
        .pixel_data(pixel_data), .hist_ready(hist_ready), .hist_valid(hist_valid),
        .hist_bin(hist_bin), .hist_count(hist_count), .hist_last(hist_last),
        .hist_sat(hist_sat), .frame_dropped(frame_dropped)
    );

    pixel_histogram_bin #(.PIX_W(PIX_W), .CNT_W(CNT4_W)) dut4 (
        .clk(clk), .rst(rst), .frame_valid(frame_valid), .line_valid(line_valid),
        .pixel_data(pixel_data), .hist_ready(hist_ready), .hist_valid(hv4),
        .hist_bin(hb4), .hist_count(hc4), .hist_last(hl4),
        .hist_sat(hs4), .frame_dropped(fd4)
    );

    typedef struct {
        int bin;
        int cnt;
        bit last;
        int cnt4;
        bit sat4;
    } beat_t;

    typedef struct {
        int w;
        int h;
        int base;
        int step;
        int rmode;
        int chk_bin;
        int exp_cnt;
    } vec_t;

    beat_t            sb_q[$];
    beat_t            mon_e;
    int               checks = 0;
    int               errors = 0;
    int               beats = 0;
    int               drops = 0;
    int               seen_cnt[16];
    bit               stall_q = 1'b0;
    logic [3:0]       st_bin;
    logic [CNT_W-1:0] st_cnt;
    logic             st_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit rdy(input int mode, input int cyc);
        case (mode)
            1:       return (cyc % 3) == 0;
            2:       return $urandom_range(0, 1) == 1;
            default: return 1'b1;
        endcase
    endfunction

    // Output monitor: scoreboard pop on every accepted beat, stall stability
    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (frame_dropped) drops++;
            if (stall_q) begin
                chk("stall_valid", hist_valid, 1);
                chk("stall_bin", hist_bin, st_bin);
                chk("stall_count", hist_count, st_cnt);
                chk("stall_last", hist_last, st_last);
            end
            if (hist_valid && hist_ready) begin
                beats++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got bin %0d count %0d, expected no beat",
                             hist_bin, hist_count);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("bin", hist_bin, mon_e.bin);
                    chk("count", hist_count, mon_e.cnt);
                    chk("last", hist_last, mon_e.last);
                    chk("sat", hist_sat, 0);
                    chk("valid4", hv4, 1);
                    chk("bin4", hb4, mon_e.bin);
                    chk("count4", hc4, mon_e.cnt4);
                    chk("sat4", hs4, mon_e.sat4);
                    seen_cnt[hist_bin] = int'(hist_count);
                end
            end
            stall_q = hist_valid && !hist_ready;
            st_bin  = hist_bin;
            st_cnt  = hist_count;
            st_last = hist_last;
        end
    end

    // Reference model: expected 16 beats for a frame
    task automatic push_frame(input int w, input int h, input int base, input int step);
        int c[16];
        int k = 0;
        bit any_sat = 1'b0;
        beat_t e;
        for (int b = 0; b < 16; b++) c[b] = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                c[((base + step * k) % 1024) / 64]++;
                k++;
            end
        end
        for (int b = 0; b < 16; b++) if (c[b] > 15) any_sat = 1'b1;
        for (int b = 0; b < 16; b++) begin
            e.bin  = b;
            e.cnt  = c[b];
            e.last = (b == 15);
            e.cnt4 = (c[b] > 15) ? 15 : c[b];
            e.sat4 = any_sat;
            sb_q.push_back(e);
        end
    endtask

    // Drives stray pixels with frame_valid low, then one w x h frame.
    // Returns with frame_valid just driven low.
    task automatic drive_frame(input int w, input int h, input int base, input int step);
        int k = 0;
        frame_valid = 1'b0;
        line_valid  = 1'b1;
        pixel_data  = 10'h0C0;
        repeat (3) tick();
        line_valid  = 1'b0;
        frame_valid = 1'b1;
        tick();
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                line_valid = 1'b1;
                pixel_data = PIX_W'((base + step * k) % 1024);
                k++;
                tick();
            end
            line_valid = 1'b0;
            tick();
        end
        line_valid = 1'b0;
        tick();
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic wait_dump(input int rmode, input int b0);
        int cyc = 0;
        while ((sb_q.size() != 0 || hist_valid) && cyc < 2000) begin
            hist_ready = rdy(rmode, cyc);
            tick();
            cyc++;
        end
        if (cyc >= 2000) begin
            checks++;
            errors++;
            $display("FAIL dump_timeout: got %0d beats left, expected 0", sb_q.size());
            sb_q.delete();
        end
        hist_ready = 1'b1;
        chk("beats_per_frame", beats - b0, 16);
    endtask

    task automatic finish_frame(input int rmode);
        int b0 = beats;
        hist_ready = 1'b1;
        tick();
        chk("valid_one_cycle_after_fall", hist_valid, 0);
        tick();
        chk("first_beat_latency", hist_valid, 1);
        wait_dump(rmode, b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        int   b0, d0, cyc;

        tbl[0] = '{4, 4, 0, 64, 0, 15, 1};
        tbl[1] = '{64, 32, 1023, 0, 0, 15, 2048};
        tbl[2] = '{4, 4, 0, 64, 1, 7, 1};
        tbl[3] = '{0, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{5, 4, 0, 0, 2, 0, 20};
        tbl[5] = '{1, 1, 0, 0, 0, 0, 1};
        tbl[6] = '{8, 8, 5, 17, 2, 0, 8};

        rst = 1'b1;
        frame_valid = 1'b0;
        line_valid = 1'b0;
        pixel_data = 10'h000;
        hist_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", hist_valid, 0);
        chk("rst_bin", hist_bin, 0);
        chk("rst_count", hist_count, 0);
        chk("rst_last", hist_last, 0);
        chk("rst_sat", hist_sat, 0);
        chk("rst_dropped", frame_dropped, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            for (int b = 0; b < 16; b++) seen_cnt[b] = -1;
            drive_frame(tbl[i].w, tbl[i].h, tbl[i].base, tbl[i].step);
            push_frame(tbl[i].w, tbl[i].h, tbl[i].base, tbl[i].step);
            finish_frame(tbl[i].rmode);
            chk("table_bin_count", seen_cnt[tbl[i].chk_bin], tbl[i].exp_cnt);
        end

        // New frame while bin 5 is stalled: dropped, then next frame normal
        drive_frame(4, 4, 0, 64);
        push_frame(4, 4, 0, 64);
        b0 = beats;
        d0 = drops;
        hist_ready = 1'b1;
        cyc = 0;
        tick();
        while (!(hist_valid && hist_bin == 4'd5) && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("reach_bin5", hist_bin, 5);
        hist_ready = 1'b0;
        drive_frame(4, 4, 0, 0);
        repeat (4) tick();
        chk("drop_pulses", drops - d0, 1);
        chk("stalled_bin", hist_bin, 5);
        chk("dropped4", fd4, 0);
        wait_dump(0, b0);
        drive_frame(4, 4, 0, 64);
        push_frame(4, 4, 0, 64);
        finish_frame(0);
        chk("drops_after_recover", drops - d0, 1);

        // Reset released mid-frame: that frame must not dump
        b0 = beats;
        frame_valid = 1'b1;
        line_valid = 1'b1;
        pixel_data = 10'h000;
        repeat (5) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        line_valid = 1'b0;
        tick();
        frame_valid = 1'b0;
        repeat (30) tick();
        chk("no_dump_after_midframe_rst", beats - b0, 0);
        drive_frame(4, 4, 0, 64);
        push_frame(4, 4, 0, 64);
        finish_frame(0);

        // Reset during DUMP aborts the dump
        drive_frame(4, 4, 0, 64);
        push_frame(4, 4, 0, 64);
        hist_ready = 1'b0;
        tick();
        tick();
        chk("dump_entered", hist_valid, 1);
        b0 = beats;
        rst = 1'b1;
        sb_q.delete();
        tick();
        tick();
        rst = 1'b0;
        chk("valid_after_dump_rst", hist_valid, 0);
        chk("count_after_dump_rst", hist_count, 0);
        hist_ready = 1'b1;
        repeat (20) tick();
        chk("no_beats_after_dump_rst", beats - b0, 0);
        for (int b = 0; b < 16; b++) seen_cnt[b] = -1;
        drive_frame(8, 8, 5, 17);
        push_frame(8, 8, 5, 17);
        finish_frame(0);
        chk("recover_bin0", seen_cnt[0], 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pixel_histogram_bin.md
PIXEL_HISTOGRAM_BIN -- requirements
Module: pixel_histogram_bin

Interface
REQ-001 SHALL have parameter PIX_W, default 10, input pixel width.
REQ-002 SHALL have parameter CNT_W, default 24, bin count width; CNT_W=24 covers 1920x1280 = 2,457,600 pixels per frame.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst, input, 1; reset is synchronous to clk and active-high.
REQ-005 SHALL have port frame_valid, input, 1, high for the whole frame (camera stream).
REQ-006 SHALL have port line_valid, input, 1, high while pixel_data carries an active pixel.
REQ-007 SHALL have port pixel_data, input, PIX_W, pixel value.
REQ-008 SHALL have port hist_ready, input, 1, downstream accepts the current bin.
REQ-009 SHALL have port hist_valid, output, 1, hist_bin/hist_count/hist_last are valid.
REQ-010 SHALL have port hist_bin, output, 4, bin index 0..15.
REQ-011 SHALL have port hist_count, output, CNT_W, pixel count of hist_bin.
REQ-012 SHALL have port hist_last, output, 1, high with bin 15.
REQ-013 SHALL have port hist_sat, output, 1, sticky per frame: some bin saturated.
REQ-014 SHALL have port frame_dropped, output, 1, one-cycle pulse when a frame start is ignored.

Function
REQ-015 SHALL register frame_valid, line_valid and pixel_data in one input stage (s1) before all other logic.
REQ-016 SHALL implement FSM states WAIT_LOW, IDLE, ACCUM and DUMP.
REQ-017 WAIT_LOW SHALL go to IDLE on the first cycle s1 frame_valid=0; this prevents counting a partial frame after reset.
REQ-018 IDLE SHALL go to ACCUM on s1 frame_valid rising edge (previous s1 value 0, current 1); all 16 counters SHALL be zero on entry.
REQ-019 In ACCUM, each cycle with s1 frame_valid and s1 line_valid both high SHALL increment the counter selected by s1 pixel_data[PIX_W-1:PIX_W-4].
REQ-020 Pixels with line_valid high and frame_valid low SHALL be ignored in every state.
REQ-021 Counters SHALL saturate at 2^CNT_W-1; an increment attempted at saturation SHALL set hist_sat.
REQ-022 ACCUM SHALL go to DUMP on the s1 frame_valid falling edge; hist_valid SHALL be high in the first DUMP cycle, 2 cycles after frame_valid is first sampled low at the input.
REQ-023 In DUMP, bins SHALL be presented in order 0..15 with hist_bin = index and hist_count = that counter.
REQ-024 A bin SHALL advance only on hist_valid && hist_ready; hist_bin, hist_count and hist_last SHALL hold stable while hist_valid && !hist_ready.
REQ-025 Each counter SHALL clear to 0 in the cycle its bin is accepted.
REQ-026 Acceptance of bin 15 SHALL return the FSM to IDLE and deassert hist_valid in the next cycle.
REQ-027 hist_sat SHALL remain valid through DUMP and clear on the IDLE->ACCUM transition.
REQ-028 An s1 frame_valid rising edge during DUMP SHALL pulse frame_dropped for 1 cycle, and that frame SHALL NOT be counted.
REQ-029 After a drop, the FSM SHALL return from DUMP to WAIT_LOW (not IDLE), so the dropped frame is skipped entirely.
REQ-030 hist_valid SHALL be 0 in every state other than DUMP.
REQ-031 A frame with zero active pixels SHALL still dump 16 bins, all with hist_count=0.

Reset
REQ-032 With rst high at a clk edge: state=WAIT_LOW, all counters=0, s1 registers=0, hist_valid=0, hist_bin=0, hist_count=0, hist_last=0, hist_sat=0, frame_dropped=0.
REQ-033 rst asserted mid-ACCUM or mid-DUMP SHALL abort the operation with no further hist_valid; after release, no frame SHALL be counted until frame_valid has been sampled low.

Verification
REQ-034 4x4 frame, pixels 0,64,128,...,960 repeating, hist_ready=1 -> 16 beats; bins 0,1,...,15 each count 1; hist_last on beat 16; first beat 2 cycles after the frame_valid fall.
REQ-035 1920x1280 frame of constant 0x3FF, hist_ready=1 -> bin 15 = 2,457,600; all other bins 0; hist_sat=0.
REQ-036 hist_ready toggled 1 cycle on / 2 cycles off in DUMP -> order 0..15 preserved; outputs stable while stalled; no beats lost or duplicated.
REQ-037 CNT_W=4, 20 pixels of value 0 -> bin 0 = 15; hist_sat=1; next frame of 1 pixel -> hist_sat=0 and bin 0 = 1.
REQ-038 New frame_valid rise while bin 5 is stalled -> frame_dropped pulses once; that frame's bins are not counted; the following frame counts normally.
REQ-039 rst released while frame_valid is high mid-frame -> no DUMP for that frame; the next full frame dumps correct counts.
